store_sequencer: RTL and testbench
==================================

# store_sequencer

Sequences RV32I store instructions (SB/SH/SW) onto a single-port word-wide data memory. It computes the effective address and performs a read-modify-write for sub-word stores, merging the byte or halfword into the fetched word. It issues a single write for full-word stores. It sits between the decode/execute stage and the data memory port, and reports completion or fault back to the core.

## Interface
Parameters:
- TIMEOUT, default 255: max cycles a memory phase waits for mem_ack before aborting; 8-bit, must be ≥1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- store_valid  in  1  store request present.
- store_ready  out  1  sequencer can accept a request.
- funct3  in  3  0=SB, 1=SH, 2=SW; others illegal.
- rs1_value  in  32  base address.
- rs2_value  in  32  store data.
- immediate12_stype  in  32  sign-extended S-type offset.
- store_done  out  1  one-cycle completion pulse.
- store_fault  out  1  valid with store_done; 1 = store not performed.
- fault_cause  out  2  01 illegal funct3, 10 misaligned, 11 timeout; 00 when no fault.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; meaningful while mem_req.
- mem_addr  out  32  word address, bits[1:0] always 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid in the mem_ack cycle of a read.
- mem_ack  in  1  access complete; ignored while mem_req=0.

## Operation
- States: IDLE, READ, WRITE, RESP.
- store_ready = (state==IDLE) && !reset.
- Accept on store_valid && store_ready. Capture the following into registers; inputs are don't-care afterwards:
  - ea = rs1_value + immediate12_stype, mod 2^32.
  - off = ea[1:0].
  - funct3.
  - rs2_value.
- IDLE transitions on accept:
  - funct3 > 2: go to RESP with fault 01; no memory access.
  - Misaligned (see Configuration): go to RESP with fault 10; no memory access.
  - SW: go to WRITE with mem_wdata = rs2_value.
  - SB/SH: go to READ.
- READ:
  - Drive mem_req=1, mem_we=0, mem_addr={ea[31:2],2'b00}, stable until mem_ack.
  - On mem_ack, merge mem_rdata into a register and go to WRITE:
    - SB: replace byte lane off with rs2[7:0].
    - SH: replace halfword lane off[1] with rs2[15:0].
- WRITE:
  - Drive mem_req=1, mem_we=1, same mem_addr, mem_wdata = merged word.
  - Hold until mem_ack, then go to RESP with no fault.
- RESP: store_done=1 for one cycle with store_fault/fault_cause, then go to IDLE.
- Timeout:
  - An 8-bit counter clears on entry to READ or WRITE and increments each cycle without mem_ack.
  - When the count reaches TIMEOUT-1 with no ack, drop mem_req the next cycle and go to RESP with fault 11.
  - An ack in the same cycle as the limit wins; no fault.
- Outputs are registered or state-decoded; no combinational path from mem_ack to mem_req.
- mem_wdata and mem_we are 0 whenever mem_req=0.

## Timing
- Reset values: store_done=0, store_fault=0, fault_cause=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE. store_ready=0 while reset is high and 1 the first cycle after.
- Reset mid-operation aborts immediately: mem_req=0 the next cycle and no store_done is produced.
- Latencies (accept at cycle T, zero-wait ack):
  - SW: WRITE at T+1, store_done at T+2, ready at T+3.
  - SB/SH: READ at T+1, WRITE at T+2, store_done at T+3, ready at T+4.
  - Faulted request: store_done at T+1.
- Each wait cycle adds one cycle per phase.
- Back-to-back: a new request is accepted in the first cycle store_ready is high after RESP.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - Misaligned means SH with off[0]=1, or SW with off≠0.
  - A misaligned store faults with cause 10 and performs no memory access.
- Not defined:
  - No misalignment fault.
  - SH uses lane ea[1] and ignores ea[0].
  - SW ignores ea[1:0].
  - Cause 10 is never produced.

## Test plan
- SW, rs1=0x100, imm=0x4, rs2=0xDEADBEEF, ack same cycle -> single write to 0x104 data 0xDEADBEEF, store_done at T+2, no fault.
- SB, ea=0x203, memory word 0x11223344, rs2=0xAA -> read 0x200, write 0xAA223344, store_done at T+3.
- SH, ea=0x302, mem 0x11223344, rs2=0xBEEF, ack delayed 3 cycles per phase -> write 0xBEEF3344, mem_req/mem_addr stable through waits, done at T+9.
- funct3=3 -> no mem_req, store_done at T+1 with fault 01. SH at ea=0x401: with macro, fault 10 and no access; without macro, writes lane 0.
- TIMEOUT=4, never ack -> mem_req drops after 4 READ cycles, store_done with fault 11. Separately, reset asserted during WRITE -> mem_req=0 the next cycle, no store_done, store_ready=1 after reset release.

Source files
------------

// File: rtl/store_sequencer.sv
// store_sequencer
//   Sequences RV32I stores (SB/SH/SW) onto a single-port, word-wide data memory.
//   Full-word stores issue one write. Sub-word stores read the word, merge the
//   byte/halfword lane and write it back. Completion or fault is reported with
//   a one-cycle store_done pulse.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   : misaligned SH/SW fault with cause 2'b10, no memory access
//   undefined : SH uses lane ea[1] (ea[0] ignored), SW ignores ea[1:0]
//
// Parameters
//   TIMEOUT            cycles a memory phase waits for mem_ack (1..255)
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   store_valid/ready  request handshake (ready only in IDLE, low in reset)
//   funct3             0=SB 1=SH 2=SW, others illegal
//   rs1_value          base address
//   rs2_value          store data
//   immediate12_stype  sign-extended S-type offset
//   store_done         one-cycle completion pulse
//   store_fault        1 = store not performed (valid with store_done)
//   fault_cause        01 illegal, 10 misaligned, 11 timeout, 00 none
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   data memory port

module store_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic [31:0] immediate12_stype,
    output logic        store_done,
    output logic        store_fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    // Last count value at which a phase may still be acked.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
`ifdef STORE_MISALIGN_TRAP_EN
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured request. Only the low halfword of rs2 is kept: full-word data
    // goes straight into the mem_wdata register at accept time.
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [15:0]       rs2_q, rs2_d;
    logic              half_q, half_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              store_done_d, store_fault_d;
    logic [1:0]        fault_cause_d;

    logic [ADDR_W-1:0] ea_c;
    logic              misaligned_c;
    logic [DATA_W-1:0] merged_c;

    assign store_ready = (state_q == IDLE) && !reset;

    // Effective address of the incoming request.
    assign ea_c = rs1_value + immediate12_stype;

    // Alignment check on the incoming request.
`ifdef STORE_MISALIGN_TRAP_EN
    assign misaligned_c = ((funct3 == F3_SH) && ea_c[0]) ||
                          ((funct3 == F3_SW) && (ea_c[1:0] != 2'b00));
`else
    assign misaligned_c = 1'b0;
`endif

    // Merge captured store data into the word returned by the read phase.
    always_comb begin
        merged_c = mem_rdata;
        if (half_q) begin
            if (ea_q[1]) merged_c[31:16] = rs2_q;
            else         merged_c[15:0]  = rs2_q;
        end else begin
            case (ea_q[1:0])
                2'd0:    merged_c[7:0]   = rs2_q[7:0];
                2'd1:    merged_c[15:8]  = rs2_q[7:0];
                2'd2:    merged_c[23:16] = rs2_q[7:0];
                default: merged_c[31:24] = rs2_q[7:0];
            endcase
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        ea_d          = ea_q;
        rs2_d         = rs2_q;
        half_d        = half_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        store_done_d  = 1'b0;
        store_fault_d = 1'b0;
        fault_cause_d = CAUSE_NONE;

        case (state_q)
            IDLE: begin
                if (store_valid) begin
                    ea_d   = ea_c;
                    rs2_d  = rs2_value[15:0];
                    half_d = (funct3 == F3_SH);
                    cnt_d  = '0;
                    if (funct3 > F3_SW) begin
                        state_d       = RESP;
                        store_done_d  = 1'b1;
                        store_fault_d = 1'b1;
                        fault_cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned_c) begin
                        state_d       = RESP;
                        store_done_d  = 1'b1;
                        store_fault_d = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                        fault_cause_d = CAUSE_MISALIGN;
`endif
                    end else if (funct3 == F3_SW) begin
                        state_d     = WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {ea_c[31:2], 2'b00};
                        mem_wdata_d = rs2_value;
                    end else begin
                        state_d     = READ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {ea_c[31:2], 2'b00};
                        mem_wdata_d = '0;
                    end
                end
            end

            READ: begin
                if (mem_ack) begin
                    state_d     = WRITE;
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = RESP;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = '0;
                    mem_wdata_d   = '0;
                    store_done_d  = 1'b1;
                    store_fault_d = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end

            WRITE: begin
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    store_done_d = 1'b1;
                    // A late ack on the final allowed cycle still completes.
                    if (!mem_ack) begin
                        store_fault_d = 1'b1;
                        fault_cause_d = CAUSE_TIMEOUT;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ea_q        <= '0;
            rs2_q       <= '0;
            half_q      <= 1'b0;
            cnt_q       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            store_done  <= 1'b0;
            store_fault <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            rs2_q       <= rs2_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            store_done  <= store_done_d;
            store_fault <= store_fault_d;
            fault_cause <= fault_cause_d;
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer (TIMEOUT=4) with a behavioural
// single-word memory responder driving mem_ack after a programmable delay.
module tb_store_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        store_valid = 1'b0;
    logic        store_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_value = '0;
    logic [31:0] rs2_value = '0;
    logic [31:0] immediate12_stype = '0;
    logic        store_done;
    logic        store_fault;
    logic [1:0]  fault_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    // Memory responder state
    int          ack_delay = 0;
    logic        never_ack = 1'b0;
    int          waits = 0;
    logic [31:0] mem_word = '0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_raddr = '0;
    int          idle_viol = 0;

    store_sequencer #(.TIMEOUT(4)) dut (
        .clock(clock),
        .reset(reset),
        .store_valid(store_valid),
        .store_ready(store_ready),
        .funct3(funct3),
        .rs1_value(rs1_value),
        .rs2_value(rs2_value),
        .immediate12_stype(immediate12_stype),
        .store_done(store_done),
        .store_fault(store_fault),
        .fault_cause(fault_cause),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    // Memory model: acks after ack_delay wait cycles in each phase.
    always @(negedge clock) begin
        if (mem_req !== 1'b1 && (mem_we !== 1'b0 || mem_wdata !== 32'h0)) idle_viol++;
        if (mem_req === 1'b1 && !never_ack) begin
            if (waits == ack_delay) begin
                mem_ack = 1'b1;
                waits = 0;
                if (mem_we) begin
                    wr_count++;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                    mem_word = mem_wdata;
                end else begin
                    rd_count++;
                    last_raddr = mem_addr;
                    mem_rdata = mem_word;
                end
            end else begin
                mem_ack = 1'b0;
                waits++;
            end
        end else begin
            mem_ack = 1'b0;
            waits = 0;
        end
    end

    // Issues one request at the current negedge and follows it to completion.
    // Returns positioned on the negedge after the store_done pulse.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] imm, input logic [31:0] rs2,
                             output int done_at, output logic flt,
                             output logic [1:0] cause, output int reqc,
                             output logic addr_stable);
        logic [31:0] first_addr;
        logic        first;
        checks++;
        if (store_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept got=%b exp=1", store_ready);
        end
        funct3 = f3;
        rs1_value = rs1;
        immediate12_stype = imm;
        rs2_value = rs2;
        store_valid = 1'b1;
        @(posedge clock);
        #1;
        store_valid = 1'b0;
        funct3 = 3'd7;
        rs1_value = 32'hFFFF_FFFF;
        rs2_value = 32'h0;
        immediate12_stype = 32'h0;
        done_at = -1;
        flt = 1'bx;
        cause = 2'bxx;
        reqc = 0;
        addr_stable = 1'b1;
        first = 1'b1;
        first_addr = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                reqc++;
                if (first) begin
                    first_addr = mem_addr;
                    first = 1'b0;
                end else if (mem_addr !== first_addr) begin
                    addr_stable = 1'b0;
                end
            end
            if (store_done === 1'b1) begin
                done_at = n;
                flt = store_fault;
                cause = fault_cause;
                break;
            end
        end
        checks++;
        if (done_at < 0) begin
            failures++;
            $display("FAIL store_done_timeout got=none exp=pulse within 40 cycles");
        end else begin
            @(negedge clock);
            if (store_done !== 1'b0 || store_ready !== 1'b1) begin
                failures++;
                $display("FAIL done_pulse_then_ready got done=%b ready=%b exp done=0 ready=1",
                         store_done, store_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (store_ready !== 1'b0 || store_done !== 1'b0 || store_fault !== 1'b0 ||
            fault_cause !== 2'b00 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got ready=%b done=%b fault=%b cause=%b req=%b we=%b addr=%h wdata=%h exp all 0",
                     store_ready, store_done, store_fault, fault_cause, mem_req, mem_we, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (store_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", store_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_sw();
        int d; logic f; logic [1:0] c; int r; logic s; int wr0, rd0;
        ack_delay = 0;
        wr0 = wr_count; rd0 = rd_count;
        run_store(3'd2, 32'h100, 32'h4, 32'hDEADBEEF, d, f, c, r, s);
        checks++;
        if (d != 2 || f !== 1'b0 || c !== 2'b00) begin
            failures++;
            $display("FAIL sw_timing got done_at=%0d fault=%b cause=%b exp 2/0/00", d, f, c);
        end
        checks++;
        if (wr_count - wr0 != 1 || rd_count - rd0 != 0 || last_waddr !== 32'h104 ||
            last_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_write got wr=%0d rd=%0d addr=%h data=%h exp 1/0/00000104/deadbeef",
                     wr_count - wr0, rd_count - rd0, last_waddr, last_wdata);
        end
    endtask

    task automatic test_sb();
        int d; logic f; logic [1:0] c; int r; logic s;
        ack_delay = 0;
        mem_word = 32'h11223344;
        run_store(3'd0, 32'h200, 32'h3, 32'h123456AA, d, f, c, r, s);
        checks++;
        if (d != 3 || f !== 1'b0 || c !== 2'b00 || r != 2) begin
            failures++;
            $display("FAIL sb_timing got done_at=%0d fault=%b cause=%b req=%0d exp 3/0/00/2", d, f, c, r);
        end
        checks++;
        if (last_raddr !== 32'h200 || last_waddr !== 32'h200 || last_wdata !== 32'hAA223344) begin
            failures++;
            $display("FAIL sb_merge got raddr=%h waddr=%h data=%h exp 00000200/00000200/aa223344",
                     last_raddr, last_waddr, last_wdata);
        end
        mem_word = 32'h11223344;
        run_store(3'd0, 32'h500, 32'h1, 32'h00000077, d, f, c, r, s);
        checks++;
        if (last_wdata !== 32'h11227744 || last_waddr !== 32'h500) begin
            failures++;
            $display("FAIL sb_lane1 got addr=%h data=%h exp 00000500/11227744", last_waddr, last_wdata);
        end
    endtask

    task automatic test_sh_wait();
        int d; logic f; logic [1:0] c; int r; logic s;
        ack_delay = 3;
        mem_word = 32'h11223344;
        // 0x310 + (-14) = 0x302
        run_store(3'd1, 32'h310, 32'hFFFFFFF2, 32'h0000BEEF, d, f, c, r, s);
        ack_delay = 0;
        checks++;
        if (d != 9 || f !== 1'b0 || r != 8 || s !== 1'b1) begin
            failures++;
            $display("FAIL sh_wait_timing got done_at=%0d fault=%b req=%0d stable=%b exp 9/0/8/1", d, f, r, s);
        end
        checks++;
        if (last_waddr !== 32'h300 || last_wdata !== 32'hBEEF3344) begin
            failures++;
            $display("FAIL sh_merge got addr=%h data=%h exp 00000300/beef3344", last_waddr, last_wdata);
        end
    endtask

    task automatic test_illegal();
        int d; logic f; logic [1:0] c; int r; logic s; int wr0, rd0;
        wr0 = wr_count; rd0 = rd_count;
        run_store(3'd3, 32'h0, 32'h0, 32'h0, d, f, c, r, s);
        checks++;
        if (d != 1 || f !== 1'b1 || c !== 2'b01 || r != 0) begin
            failures++;
            $display("FAIL illegal_f3_3 got done_at=%0d fault=%b cause=%b req=%0d exp 1/1/01/0", d, f, c, r);
        end
        run_store(3'd7, 32'h40, 32'h0, 32'h1, d, f, c, r, s);
        checks++;
        if (d != 1 || f !== 1'b1 || c !== 2'b01 || r != 0 || wr_count != wr0 || rd_count != rd0) begin
            failures++;
            $display("FAIL illegal_f3_7 got done_at=%0d fault=%b cause=%b req=%0d exp 1/1/01/0", d, f, c, r);
        end
    endtask

    task automatic test_misalign();
        int d; logic f; logic [1:0] c; int r; logic s;
        mem_word = 32'h11223344;
        run_store(3'd1, 32'h400, 32'h1, 32'h00005566, d, f, c, r, s);
`ifdef STORE_MISALIGN_TRAP_EN
        checks++;
        if (d != 1 || f !== 1'b1 || c !== 2'b10 || r != 0) begin
            failures++;
            $display("FAIL sh_misalign got done_at=%0d fault=%b cause=%b req=%0d exp 1/1/10/0", d, f, c, r);
        end
`else
        checks++;
        if (d != 3 || f !== 1'b0 || c !== 2'b00 || last_waddr !== 32'h400 || last_wdata !== 32'h11225566) begin
            failures++;
            $display("FAIL sh_odd_lane0 got done_at=%0d fault=%b addr=%h data=%h exp 3/0/00000400/11225566",
                     d, f, last_waddr, last_wdata);
        end
`endif
        run_store(3'd2, 32'h100, 32'h6, 32'h0BADF00D, d, f, c, r, s);
`ifdef STORE_MISALIGN_TRAP_EN
        checks++;
        if (d != 1 || f !== 1'b1 || c !== 2'b10 || r != 0) begin
            failures++;
            $display("FAIL sw_misalign got done_at=%0d fault=%b cause=%b req=%0d exp 1/1/10/0", d, f, c, r);
        end
`else
        checks++;
        if (d != 2 || f !== 1'b0 || last_waddr !== 32'h104 || last_wdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL sw_unaligned got done_at=%0d fault=%b addr=%h data=%h exp 2/0/00000104/0badf00d",
                     d, f, last_waddr, last_wdata);
        end
`endif
    endtask

    task automatic test_timeout();
        int d; logic f; logic [1:0] c; int r; logic s; int wr0;
        never_ack = 1'b1;
        wr0 = wr_count;
        run_store(3'd0, 32'h700, 32'h2, 32'h55, d, f, c, r, s);
        never_ack = 1'b0;
        checks++;
        if (d != 5 || f !== 1'b1 || c !== 2'b11 || r != 4 || wr_count != wr0) begin
            failures++;
            $display("FAIL read_timeout got done_at=%0d fault=%b cause=%b req=%0d exp 5/1/11/4", d, f, c, r);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        never_ack = 1'b1;
        funct3 = 3'd2;
        rs1_value = 32'h800;
        immediate12_stype = 32'h0;
        rs2_value = 32'h12345678;
        store_valid = 1'b1;
        @(posedge clock);
        #1;
        store_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL write_phase_active got req=%b we=%b exp 1/1", mem_req, mem_we);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b0 || store_done !== 1'b0 || store_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got req=%b done=%b ready=%b exp 0/0/0", mem_req, store_done, store_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        never_ack = 1'b0;
        #1;
        checks++;
        if (store_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_abort got=%b exp=1", store_ready);
        end
        seen_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (store_done === 1'b1 || mem_req === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL no_done_after_abort got=%0d cycles exp=0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int d; logic f; logic [1:0] c; int r; logic s;
        ack_delay = 0;
        run_store(3'd2, 32'h600, 32'h0, 32'hCAFEF00D, d, f, c, r, s);
        checks++;
        if (d != 2 || last_wdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_first got done_at=%0d data=%h exp 2/cafef00d", d, last_wdata);
        end
        run_store(3'd0, 32'h600, 32'h1, 32'h5A, d, f, c, r, s);
        checks++;
        if (d != 3 || f !== 1'b0 || last_raddr !== 32'h600 || last_wdata !== 32'hCAFE5A0D) begin
            failures++;
            $display("FAIL b2b_second got done_at=%0d fault=%b raddr=%h data=%h exp 3/0/00000600/cafe5a0d",
                     d, f, last_raddr, last_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_sh_wait();
        test_illegal();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (idle_viol != 0) begin
            failures++;
            $display("FAIL idle_we_wdata_zero got=%0d cycles exp=0", idle_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
